// File: rtl/uart_frame_tx_seq.sv
// UART frame transmitter with a word FIFO: start, LSB-first data, optional parity, 1 or 2 stops.
// Optional line-break generator is compiled in with `define UART_TX_BREAK_EN (adds SEND_BREAK).
module uart_frame_tx_seq #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int PTR_W      = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  BIT_TICK,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   input  logic [DATA_WIDTH-1:0] WR_DATA,
   input  logic                  WR_VALID,
`ifdef UART_TX_BREAK_EN
   input  logic                  SEND_BREAK,
`endif
   output logic                  WR_READY,
   output logic                  TX_OUT,
   output logic                  BUSY,
   output logic                  FIFO_EMPTY,
   output logic                  FRAME_DONE,
   output logic [2:0]            dbg_state
);

   // Write side: a word is accepted on a cycle with WR_VALID & WR_READY; nothing is
   // accepted while WR_READY is low, so the producer must hold the word until then.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5
`ifdef UART_TX_BREAK_EN
      ,ST_BREAK = 3'd6
`endif
   } state_t;

   localparam int CNT_W = $clog2(DATA_WIDTH + 3);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W:0]   FILL_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   FILL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [PTR_W:0]        count;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  par_q, par_en_q, stop2_q;
   logic                  push, pop, last_stop;
   logic [DATA_WIDTH-1:0] head;

   assign WR_READY   = (count != FILL_FULL);
   assign FIFO_EMPTY = (count == '0);
   assign push       = WR_VALID & WR_READY;
   assign head       = mem[rd_ptr];
   assign BUSY       = (state_q != ST_IDLE);
   assign dbg_state  = state_q;

`ifdef UART_TX_BREAK_EN
   localparam logic [CNT_W-1:0] LAST_BRK = CNT_W'(DATA_WIDTH + 2);
   logic brk_pend, brk_req, brk_take;
   assign brk_req = SEND_BREAK | brk_pend;

   // A break requested mid-frame is remembered until the FSM is back in IDLE.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)             brk_pend <= 1'b0;
      else if (brk_take)   brk_pend <= 1'b0;
      else if (SEND_BREAK) brk_pend <= 1'b1;
   end
`endif

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= WR_DATA;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      count <= count + FILL_ONE;
         else if (pop && !push) count <= count - FILL_ONE;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      last_stop  = 1'b0;
      TX_OUT     = 1'b1;
      FRAME_DONE = 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_take   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (BIT_TICK) begin
`ifdef UART_TX_BREAK_EN
               if (brk_req) begin
                  brk_take = 1'b1;
                  state_d  = ST_BREAK;
               end else
`endif
               if (!FIFO_EMPTY) begin
                  pop     = 1'b1;
                  state_d = ST_START;
               end
            end
         end
         ST_START: begin
            TX_OUT = 1'b0;
            if (BIT_TICK) state_d = ST_DATA;
         end
         ST_DATA: begin
            TX_OUT = shift_q[0];
            if (BIT_TICK && bit_cnt == LAST_DATA)
               state_d = par_en_q ? ST_PARITY : ST_STOP1;
         end
         ST_PARITY: begin
            TX_OUT = par_q;
            if (BIT_TICK) state_d = ST_STOP1;
         end
         ST_STOP1: begin
            if (BIT_TICK) begin
               if (stop2_q) state_d = ST_STOP2;
               else         last_stop = 1'b1;
            end
         end
         ST_STOP2: begin
            if (BIT_TICK) last_stop = 1'b1;
         end
`ifdef UART_TX_BREAK_EN
         ST_BREAK: begin
            TX_OUT = 1'b0;
            if (BIT_TICK && bit_cnt == LAST_BRK) state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
      // Chaining straight into the next start bit keeps frames gap-free.
      if (last_stop) begin
         FRAME_DONE = 1'b1;
         if (!FIFO_EMPTY) begin
            pop     = 1'b1;
            state_d = ST_START;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   // Frame configuration is captured at pop time and held for the whole frame.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shift_q  <= '0;
         bit_cnt  <= '0;
         par_q    <= 1'b0;
         par_en_q <= 1'b0;
         stop2_q  <= 1'b0;
      end else if (pop) begin
         shift_q  <= head;
         par_q    <= (^head) ^ PAR_TYP;
         par_en_q <= PAR_EN;
         stop2_q  <= STOP2;
         bit_cnt  <= '0;
      end else if (BIT_TICK && state_q == ST_DATA) begin
         shift_q <= shift_q >> 1;
         bit_cnt <= bit_cnt + CNT_ONE;
      end
`ifdef UART_TX_BREAK_EN
      else if (brk_take) begin
         bit_cnt <= '0;
      end else if (BIT_TICK && state_q == ST_BREAK) begin
         bit_cnt <= bit_cnt + CNT_ONE;
      end
`endif
   end

endmodule

// File: tb/tb_uart_frame_tx_seq.sv
// Directed bench for uart_frame_tx_seq: frame shapes, parity/stop modes, chaining, FIFO full, reset.
// Line bits are captured once per BIT_TICK and compared against hand-computed vectors.
module tb_uart_frame_tx_seq;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       BIT_TICK = 1'b0;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic       STOP2 = 1'b0;
   logic [7:0] WR_DATA = 8'h00;
   logic       WR_VALID = 1'b0;
   logic       send_break = 1'b0;
   logic       WR_READY, TX_OUT, BUSY, FIFO_EMPTY, FRAME_DONE;
   logic [2:0] dbg_state;

   int  n_checks = 0;
   int  n_pass = 0;
   int  done_cnt = 0;
   logic tick_en = 1'b0;

   uart_frame_tx_seq #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .PTR_W(3)) dut (
      .CLK(CLK), .RST(RST), .BIT_TICK(BIT_TICK), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
      .STOP2(STOP2), .WR_DATA(WR_DATA), .WR_VALID(WR_VALID),
`ifdef UART_TX_BREAK_EN
      .SEND_BREAK(send_break),
`endif
      .WR_READY(WR_READY), .TX_OUT(TX_OUT), .BUSY(BUSY), .FIFO_EMPTY(FIFO_EMPTY),
      .FRAME_DONE(FRAME_DONE), .dbg_state(dbg_state)
   );

   // clock / tick generation
   always #5 CLK = ~CLK;

   initial begin : tick_gen
      logic [1:0] div;
      div = 2'd0;
      forever begin
         @(negedge CLK);
         if (!tick_en) begin
            div      = 2'd0;
            BIT_TICK = 1'b0;
         end else begin
            div      = div + 2'd1;
            BIT_TICK = (div == 2'd3);
         end
      end
   end

   initial begin : done_mon
      forever begin
         @(negedge CLK);
         #1;
         if (FRAME_DONE) done_cnt++;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   // driver tasks
   task automatic write_word(input logic [7:0] w);
      @(negedge CLK);
      WR_DATA  = w;
      WR_VALID = 1'b1;
      @(negedge CLK);
      WR_VALID = 1'b0;
   endtask

   // Captures n bit periods: bits[i] is TX_OUT just after tick i, done[i] is FRAME_DONE during tick i.
   task automatic capture(input int n, output logic [31:0] bits, output logic [31:0] done,
                          output logic stable, output logic tout);
      bits = '0; done = '0; stable = 1'b1; tout = 1'b0;
      for (int i = 0; i < n; i++) begin
         int   cyc;
         logic seen;
         cyc = 0; seen = 1'b0;
         while (!seen && cyc < 64) begin
            @(negedge CLK);
            #1;
            if (i > 0 && TX_OUT !== bits[i-1]) stable = 1'b0;
            if (BIT_TICK) begin
               seen    = 1'b1;
               done[i] = FRAME_DONE;
            end
            cyc++;
         end
         if (!seen) tout = 1'b1;
         @(posedge CLK);
         #1;
         bits[i] = TX_OUT;
      end
   endtask

   // tests
   task automatic test_reset();
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      n_checks++; if (TX_OUT !== 1'b1) $display("FAIL reset_tx: got %b expected 1", TX_OUT); else n_pass++;
      n_checks++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b expected 0", BUSY); else n_pass++;
      n_checks++; if (FRAME_DONE !== 1'b0) $display("FAIL reset_done: got %b expected 0", FRAME_DONE); else n_pass++;
      n_checks++; if (FIFO_EMPTY !== 1'b1) $display("FAIL reset_empty: got %b expected 1", FIFO_EMPTY); else n_pass++;
      n_checks++; if (WR_READY !== 1'b1) $display("FAIL reset_ready: got %b expected 1", WR_READY); else n_pass++;
      n_checks++; if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state); else n_pass++;
   endtask

   task automatic test_even_parity();
      logic [31:0] bits, done;
      logic        stable, tout;
      int          d0;
      @(negedge CLK);
      PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
      write_word(8'hAA);
      d0 = done_cnt;
      tick_en = 1'b1;
      capture(12, bits, done, stable, tout);
      tick_en = 1'b0;
      // 0,0,1,0,1,0,1,0,1,0,1 then idle 1
      n_checks++; if (bits[11:0] !== 12'hD54) $display("FAIL even_bits: got %h expected d54", bits[11:0]); else n_pass++;
      n_checks++; if (done[11:0] !== 12'h800) $display("FAIL even_done: got %h expected 800", done[11:0]); else n_pass++;
      n_checks++; if (done_cnt - d0 !== 1) $display("FAIL even_done_cnt: got %0d expected 1", done_cnt - d0); else n_pass++;
      n_checks++; if (!stable || tout) $display("FAIL even_timing: got stable=%b timeout=%b expected 1/0", stable, tout); else n_pass++;
      n_checks++; if (BUSY !== 1'b0) $display("FAIL even_busy_after: got %b expected 0", BUSY); else n_pass++;
   endtask

   task automatic test_odd_parity();
      logic [31:0] bits, done;
      logic        stable, tout;
      @(negedge CLK);
      PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b0;
      write_word(8'hCC);
      tick_en = 1'b1;
      capture(12, bits, done, stable, tout);
      tick_en = 1'b0;
      // 0 | 0,0,1,1,0,0,1,1 | parity 1 | stop 1 | idle 1
      n_checks++; if (bits[11:0] !== 12'hF98) $display("FAIL odd_bits: got %h expected f98", bits[11:0]); else n_pass++;
      n_checks++; if (done[11:0] !== 12'h800) $display("FAIL odd_done: got %h expected 800", done[11:0]); else n_pass++;
      n_checks++; if (!stable || tout) $display("FAIL odd_timing: got stable=%b timeout=%b expected 1/0", stable, tout); else n_pass++;
   endtask

   task automatic test_stop2_config_hold();
      logic [31:0] b1, d1, b2, d2;
      logic        s1, t1, s2, t2;
      logic [11:0] bits, done;
      @(negedge CLK);
      PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b1;
      write_word(8'h0F);
      tick_en = 1'b1;
      capture(1, b1, d1, s1, t1);
      // mid-frame changes must not affect the frame already started
      PAR_EN = 1'b1; STOP2 = 1'b0;
      capture(11, b2, d2, s2, t2);
      tick_en = 1'b0;
      bits = {b2[10:0], b1[0]};
      done = {d2[10:0], d1[0]};
      // 0,1,1,1,1,0,0,0,0,1,1 then idle 1
      n_checks++; if (bits !== 12'hE1E) $display("FAIL stop2_bits: got %h expected e1e", bits); else n_pass++;
      n_checks++; if (done !== 12'h800) $display("FAIL stop2_done: got %h expected 800", done); else n_pass++;
      n_checks++; if (!s2 || t1 || t2) $display("FAIL stop2_timing: got stable=%b timeout=%b expected 1/0", s2, t1 | t2); else n_pass++;
      PAR_EN = 1'b0; STOP2 = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] bits, done;
      logic        stable, tout;
      int          d0;
      @(negedge CLK);
      PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
      write_word(8'h01);
      write_word(8'h02);
      write_word(8'h03);
      d0 = done_cnt;
      tick_en = 1'b1;
      capture(31, bits, done, stable, tout);
      tick_en = 1'b0;
      // frames 0x202, 0x204, 0x206 (10 bits each, no gap), then idle 1
      n_checks++; if (bits[30:0] !== 31'h60681202) $display("FAIL b2b_bits: got %h expected 60681202", bits[30:0]); else n_pass++;
      n_checks++; if (done[30:0] !== 31'h40100400) $display("FAIL b2b_done: got %h expected 40100400", done[30:0]); else n_pass++;
      n_checks++; if (done_cnt - d0 !== 3) $display("FAIL b2b_done_cnt: got %0d expected 3", done_cnt - d0); else n_pass++;
      n_checks++; if (FIFO_EMPTY !== 1'b1) $display("FAIL b2b_empty: got %b expected 1", FIFO_EMPTY); else n_pass++;
      n_checks++; if (!stable || tout) $display("FAIL b2b_timing: got stable=%b timeout=%b expected 1/0", stable, tout); else n_pass++;
   endtask

   task automatic test_fifo_full();
      logic [31:0] bits, done;
      logic        stable, tout;
      logic [9:0]  exp;
      logic [7:0]  w;
      for (int i = 0; i < 9; i++) begin
         @(negedge CLK);
         WR_DATA  = 8'h10 + 8'(i);
         WR_VALID = 1'b1;
         n_checks++;
         if (WR_READY !== (i < 8)) $display("FAIL full_ready_%0d: got %b expected %b", i, WR_READY, (i < 8)); else n_pass++;
      end
      @(negedge CLK);
      WR_VALID = 1'b0;
      n_checks++; if (FIFO_EMPTY !== 1'b0) $display("FAIL full_empty: got %b expected 0", FIFO_EMPTY); else n_pass++;
      tick_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         capture(10, bits, done, stable, tout);
         w   = 8'h10 + 8'(k);
         exp = {1'b1, w, 1'b0};
         n_checks++; if (bits[9:0] !== exp || tout) $display("FAIL full_frame_%0d: got %h expected %h", k, bits[9:0], exp); else n_pass++;
         n_checks++; if (done[9:0] !== ((k == 0) ? 10'h000 : 10'h001)) $display("FAIL full_done_%0d: got %h expected %h", k, done[9:0], (k == 0) ? 10'h000 : 10'h001); else n_pass++;
      end
      capture(1, bits, done, stable, tout);
      tick_en = 1'b0;
      n_checks++; if (bits[0] !== 1'b1 || done[0] !== 1'b1) $display("FAIL full_tail: got tx=%b done=%b expected 1/1", bits[0], done[0]); else n_pass++;
      n_checks++; if (FIFO_EMPTY !== 1'b1 || BUSY !== 1'b0) $display("FAIL full_drained: got empty=%b busy=%b expected 1/0", FIFO_EMPTY, BUSY); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] bits, done;
      logic        stable, tout;
      @(negedge CLK);
      PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
      write_word(8'h55);
      write_word(8'h33);
      tick_en = 1'b1;
      capture(3, bits, done, stable, tout);
      n_checks++; if (bits[2:0] !== 3'b010) $display("FAIL rst_pre_bits: got %b expected 010", bits[2:0]); else n_pass++;
      #2;
      RST = 1'b1;
      #1;
      n_checks++; if (TX_OUT !== 1'b1) $display("FAIL rst_mid_tx: got %b expected 1", TX_OUT); else n_pass++;
      n_checks++; if (BUSY !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", BUSY); else n_pass++;
      n_checks++; if (FIFO_EMPTY !== 1'b1) $display("FAIL rst_mid_empty: got %b expected 1", FIFO_EMPTY); else n_pass++;
      n_checks++; if (dbg_state !== 3'd0) $display("FAIL rst_mid_state: got %0d expected 0", dbg_state); else n_pass++;
      tick_en = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      write_word(8'h3C);
      tick_en = 1'b1;
      capture(11, bits, done, stable, tout);
      tick_en = 1'b0;
      // 0 | 0,0,1,1,1,1,0,0 | 1 | idle 1
      n_checks++; if (bits[10:0] !== 11'h678) $display("FAIL rst_after_bits: got %h expected 678", bits[10:0]); else n_pass++;
      n_checks++; if (done[10:0] !== 11'h400) $display("FAIL rst_after_done: got %h expected 400", done[10:0]); else n_pass++;
   endtask

   initial begin : main
      test_reset();
      test_even_parity();
      test_odd_parity();
      test_stop2_config_hold();
      test_back_to_back();
      test_fifo_full();
      test_reset_mid_frame();
      repeat (4) @(negedge CLK);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
